// File: rtl/serial_add_ctrl_if.sv
// Operand/result bus of the bit-serial adder controller. The ovf signal exists
// only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
) ();
  // Valid/ready: a transfer happens on the rising edge where valid && ready are
  // both high; the producer holds its payload stable from valid until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial a+b+cin: one gate-level full-adder cell reused LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus,
  output logic [1:0]       state_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  // Shared full-adder cell: two half adders and an OR, kept at gate level.
  logic hs1, hc1, hc2, cell_s, cell_co;
  xor u_ha1_s (hs1, a_sr_q[0], b_sr_q[0]);
  and u_ha1_c (hc1, a_sr_q[0], b_sr_q[0]);
  xor u_ha2_s (cell_s, hs1, carry_q);
  and u_ha2_c (hc2, hs1, carry_q);
  or  u_co    (cell_co, hc1, hc2);

  // New bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    sum_sr_d           = sum_sr_q >> 1;
    sum_sr_d[WIDTH-1]  = cell_s;
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q  <= cell_co;
          sum_sr_q <= sum_sr_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          if (last_bit) begin
            // carry_q still holds the carry into the MSB on this edge.
            cnt_q   <= '0;
            sum_q   <= sum_sr_d;
            cout_q  <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= carry_q ^ cell_co;
`endif
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
  assign state_o       = state_q;
endmodule
